// File: rtl/dnn_axis_tx.sv
// -----------------------------------------------------------------------------
// dnn_axis_tx
//
// AXI-Stream transmitter for the dnn classification results. It takes the
// return path to the MicroBlaze subsystem through the DMA S2MM channel.
// The block collects NUM_OUTPUTS signed output-neuron words from the dnn
// result port and queues them in a small FIFO. While collecting, it tracks the
// signed argmax. Each packet leaves as NUM_OUTPUTS data beats followed by one
// summary beat, which carries the argmax index and asserts tlast.
//
// Ports
//   s_axi_aclk     in   sole clock, rising edge
//   s_axi_aresetn  in   asynchronous active-low reset
//   clear          in   synchronous soft flush (FIFO, counter, argmax)
//   res_data       in   signed result word from dnn
//   res_valid      in   res_data valid
//   res_ready      out  result word accepted this cycle
//   m_axis_tdata   out  stream data (0 while tvalid=0)
//   m_axis_tkeep   out  all ones while tvalid=1, else 0
//   m_axis_tlast   out  marks the summary beat
//   m_axis_tvalid  out  beat available
//   m_axis_tready  in   downstream accepts the beat
//   tx_done        out  one-cycle pulse after the summary beat handshakes
//   busy           out  packet partially collected or FIFO non-empty
//                       (registered, one cycle behind)
// -----------------------------------------------------------------------------
module dnn_axis_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 10,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDX_W       = $clog2(NUM_OUTPUTS)
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     res_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      tx_done,
  output logic                      busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic {
    COLLECT,
    SUMMARY
  } state_t;

  // ---------------------------------------------------------------------------
  // Collection state
  // ---------------------------------------------------------------------------
  state_t                        state;
  logic [IDX_W-1:0]              cnt;
  logic [IDX_W-1:0]              arg_idx;
  logic signed [DATA_WIDTH-1:0]  arg_max;
  logic                          arg_valid;

  // ---------------------------------------------------------------------------
  // FIFO storage: one extra bit per entry carries the packet's last flag
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              fill;
  logic [DATA_WIDTH:0]           head;
  logic [DATA_WIDTH:0]           push_word;
  logic [DATA_WIDTH-1:0]         summary_word;

  logic full;
  logic empty;
  logic res_hs;
  logic sum_push;
  logic push;
  logic pop;

  assign full  = (fill == CNT_W'(FIFO_DEPTH));
  assign empty = (fill == '0);

  // res_ready depends only on registered state and the reset pin. The FIFO
  // never accepts a push while full, even when a pop happens in the same cycle.
  assign res_ready = (state == COLLECT) && !full && s_axi_aresetn;

  // clear overrides every event in its cycle: handshakes are discarded.
  assign res_hs   = res_valid && res_ready && !clear;
  assign sum_push = (state == SUMMARY) && !full && !clear;
  assign push     = res_hs || sum_push;
  assign pop      = m_axis_tvalid && m_axis_tready && !clear;

  // The summary word is the argmax index, zero-extended to the full data width.
  assign summary_word = arg_valid ? {{(DATA_WIDTH-IDX_W){1'b0}}, arg_idx} : '0;
  assign push_word    = sum_push ? {1'b1, summary_word} : {1'b0, res_data};

  // ---------------------------------------------------------------------------
  // Input FSM, counter and running argmax
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and process ordering cannot matter.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state     <= COLLECT;
      cnt       <= '0;
      arg_idx   <= '0;
      arg_max   <= '0;
      arg_valid <= 1'b0;
    end else if (clear) begin
      state     <= COLLECT;
      cnt       <= '0;
      arg_idx   <= '0;
      arg_max   <= '0;
      arg_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (res_hs) begin
            // Word 0 always seeds the argmax. A later word replaces it only
            // when strictly greater, so a tie keeps the lowest index.
            if ((cnt == '0) || ($signed(res_data) > arg_max)) begin
              arg_max <= $signed(res_data);
              arg_idx <= cnt;
            end
            arg_valid <= 1'b1;
            cnt       <= cnt + IDX_W'(1);
            if (cnt == IDX_W'(NUM_OUTPUTS - 1)) begin
              state <= SUMMARY;
            end
          end
        end
        SUMMARY: begin
          // Hold here until there is room for the summary entry.
          if (!full) begin
            cnt   <= '0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fill <= fill + CNT_W'(1);
      end else if (!push && pop) begin
        fill <= fill - CNT_W'(1);
      end
    end
  end

  // NOTE: the storage array has no reset. Outputs are qualified by the
  // occupancy count, which is reset, so stale contents are never visible.
  always_ff @(posedge s_axi_aclk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream output: first-word-fall-through from the storage flops
  // ---------------------------------------------------------------------------
  // The head entry stays stable while tvalid=1. While the FIFO is non-empty,
  // a write can land on rd_ptr only when the FIFO is full, and no push
  // occurs when full.
  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[DATA_WIDTH];
  assign m_axis_tkeep  = {KEEP_W{m_axis_tvalid}};

  // ---------------------------------------------------------------------------
  // Status: packet-completion pulse and busy flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // pop is already suppressed by clear, so tx_done is suppressed as well.
      tx_done <= pop && m_axis_tlast;
      busy    <= !clear && ((state == SUMMARY) || (cnt != '0) || !empty);
    end
  end

endmodule

// File: tb/tb_dnn_axis_tx.sv
// -----------------------------------------------------------------------------
// tb_dnn_axis_tx
//
// Directed testbench for dnn_axis_tx with the default parameters (32-bit data,
// 10 outputs, 16-entry FIFO). Inputs change on the falling clock edge. A
// monitor samples just after that edge, records every output handshake, and
// tracks the expected tx_done pulse. Expected beat streams are built from
// packet contents and hand-computed argmax indices.
// -----------------------------------------------------------------------------
module tb_dnn_axis_tx;

  typedef int pkt_t [10];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        tx_done;
  logic        busy;

  always #5 clk = ~clk;

  dnn_axis_tx #(
    .DATA_WIDTH  (32),
    .NUM_OUTPUTS (10),
    .FIFO_DEPTH  (16)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .clear         (clear),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .tx_done       (tx_done),
    .busy          (busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_d [$];
  logic        got_l [$];
  logic [31:0] exp_d [$];
  logic        exp_l [$];
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  logic        prev_last_hs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Output monitor: record handshakes, and expect tx_done exactly one cycle
  // after each tlast handshake.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      check("tx_done", tx_done, prev_last_hs);
      if (tx_done) done_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        check("tkeep", m_axis_tkeep, 4'hF);
      end
      prev_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast && !clear;
    end else begin
      prev_last_hs = 1'b0;
    end
  end

  // Drive one word and return on the falling edge after it was accepted.
  task automatic send(input logic [31:0] d);
    int t = 0;
    res_data  = d;
    res_valid = 1'b1;
    while (!res_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!res_ready) check("send_timeout", res_ready, 1);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic send_packet(input pkt_t v);
    for (int i = 0; i < 10; i++) send(32'(v[i]));
  endtask

  task automatic add_packet(input pkt_t v, input int idx);
    for (int i = 0; i < 10; i++) begin
      exp_d.push_back(32'(v[i]));
      exp_l.push_back(1'b0);
    end
    exp_d.push_back(32'(idx));
    exp_l.push_back(1'b1);
  endtask

  task automatic drain();
    int t = 0;
    m_axis_tready = 1'b1;
    while (m_axis_tvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (m_axis_tvalid) check("drain_timeout", m_axis_tvalid, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input string tag, input int n_pkts);
    check({tag, "_beats"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
    end
    check({tag, "_tx_done_count"}, done_cnt, n_pkts);
    got_d.delete();
    got_l.delete();
    exp_d.delete();
    exp_l.delete();
    done_cnt = 0;
  endtask

  pkt_t p_seq  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  pkt_t p_tie  = '{-5, -5, -5, 100, -5, -5, -5, 100, -5, -5};
  pkt_t p_eq   = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
  pkt_t p_up   = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
  pkt_t p_dn2  = '{29, 28, 27, 26, 25, 24, 23, 22, 21, 20};
  pkt_t p_a    = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
  pkt_t p_b    = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
  pkt_t p_dn   = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  pkt_t p_mix  = '{3, -7, 12, 12, 0, 5, -100, 11, 2, 1};

  initial begin
    // Reset state.
    #12;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_busy", busy, 0);
    check("rst_res_ready", res_ready, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_res_ready", res_ready, 1);
    check("idle_busy", busy, 0);

    // Packet 0..9 with tready=1. The first word is visible the cycle after
    // it is accepted.
    m_axis_tready = 1'b1;
    send(32'd0);
    check("latency_tvalid", m_axis_tvalid, 1);
    check("latency_tdata", m_axis_tdata, 0);
    for (int i = 1; i < 10; i++) send(32'(p_seq[i]));
    add_packet(p_seq, 9);
    drain();
    verify("seq", 1);
    check("seq_busy_idle", busy, 0);

    // Tie keeps the lowest index; all-equal input selects index 0.
    send_packet(p_tie);
    add_packet(p_tie, 3);
    drain();
    verify("tie", 1);
    send_packet(p_eq);
    add_packet(p_eq, 0);
    drain();
    verify("equal", 1);

    // Two packets with tready=0: the FIFO fills after 16 entries.
    m_axis_tready = 1'b0;
    send_packet(p_up);
    for (int i = 0; i < 4; i++) send(32'(p_dn2[i]));
    check("fill15_res_ready", res_ready, 1);
    send(32'(p_dn2[4]));
    check("full_res_ready", res_ready, 0);
    check("full_tvalid", m_axis_tvalid, 1);
    check("full_head", m_axis_tdata, 32'd10);
    check("full_busy", busy, 1);
    m_axis_tready = 1'b1;
    for (int i = 5; i < 10; i++) send(32'(p_dn2[i]));
    add_packet(p_up, 9);
    add_packet(p_dn2, 0);
    drain();
    verify("two_pkts", 2);

    // The final data word lands in the last free slot, so the FSM holds in
    // SUMMARY until a pop makes room.
    m_axis_tready = 1'b0;
    send_packet(p_a);
    m_axis_tready = 1'b1;
    repeat (5) @(negedge clk);
    m_axis_tready = 1'b0;
    send_packet(p_b);
    check("sum_full_ready0", res_ready, 0);
    @(negedge clk);
    check("sum_full_hold", res_ready, 0);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    check("sum_after_pop_ready", res_ready, 0);
    check("sum_after_pop_tvalid", m_axis_tvalid, 1);
    @(negedge clk);
    check("sum_pushed_full", res_ready, 0);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    check("sum_pushed_collect", res_ready, 1);
    add_packet(p_a, 4);
    add_packet(p_b, 0);
    drain();
    verify("full_sum", 2);

    // clear after 4 words, with a discarded handshake in the same cycle.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(5 + i));
    check("pre_clear_tvalid", m_axis_tvalid, 1);
    clear     = 1'b1;
    res_valid = 1'b1;
    res_data  = 32'd77;
    @(negedge clk);
    clear     = 1'b0;
    res_valid = 1'b0;
    check("clear_tvalid", m_axis_tvalid, 0);
    check("clear_tlast", m_axis_tlast, 0);
    check("clear_tkeep", m_axis_tkeep, 0);
    @(negedge clk);
    check("clear_busy", busy, 0);
    m_axis_tready = 1'b1;
    send_packet(p_dn);
    add_packet(p_dn, 0);
    drain();
    verify("after_clear", 1);

    // Asynchronous reset mid-output with tready=0.
    m_axis_tready = 1'b0;
    send(32'h11);
    send(32'h22);
    send(32'h33);
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 0);
    check("arst_tlast", m_axis_tlast, 0);
    check("arst_tdata", m_axis_tdata, 0);
    check("arst_tkeep", m_axis_tkeep, 0);
    check("arst_tx_done", tx_done, 0);
    check("arst_res_ready", res_ready, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    got_d.delete();
    got_l.delete();
    done_cnt = 0;
    mon_en   = 1'b1;
    @(negedge clk);
    check("post_rst_tvalid", m_axis_tvalid, 0);
    m_axis_tready = 1'b1;
    send_packet(p_mix);
    add_packet(p_mix, 2);
    drain();
    verify("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dnn_axis_tx.md
# dnn_axis_tx

AXI-Stream transmitter carrying `dnn` classification results back to the MicroBlaze subsystem through the DMA S2MM channel. It is the return path of the MM2S stream that feeds `dnn` its inputs. It accepts NUM_OUTPUTS output-neuron words from the `dnn` result port and buffers them in a FIFO. It tracks the signed argmax and emits each packet as NUM_OUTPUTS data beats plus one summary beat, with tlast on the summary beat. It pulses `tx_done` when a packet has fully left the block.

## Interface
- DATA_WIDTH, 32, width of result words and of tdata
- NUM_OUTPUTS, 10, output-neuron words per packet (>=2)
- FIFO_DEPTH, 16, FIFO entries (power of two, >=4)
- IDX_W, $clog2(NUM_OUTPUTS), width of the argmax index
- s_axi_aclk  in  1  sole clock, rising edge
- s_axi_aresetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous soft flush; active-high, single cycle
- res_data  in  DATA_WIDTH  signed result word from `dnn`
- res_valid  in  1  res_data valid
- res_ready  out  1  block accepts res_data this cycle
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tkeep  out  DATA_WIDTH/8  all ones whenever tvalid=1, else 0
- m_axis_tlast  out  1  marks the summary beat
- m_axis_tvalid  out  1  beat available
- m_axis_tready  in  1  downstream accepts the beat
- tx_done  out  1  one-cycle pulse after the summary beat handshakes
- busy  out  1  1 while a packet is partially collected or the FIFO is non-empty

## Operation
- FIFO: FIFO_DEPTH x (DATA_WIDTH+1); the extra bit is `last`. First-word-fall-through, registered head.
- Input FSM states:
  - COLLECT: `res_ready = !full && s_axi_aresetn`. On each handshake:
    - push {0, res_data}.
    - `cnt` increments.
    - Argmax updates. Word 0 always loads max/idx. Later words update only if strictly greater (signed), so ties keep the lowest index.
    - On handshake of word NUM_OUTPUTS-1, go to SUMMARY.
  - SUMMARY: `res_ready=0`. When `!full`, push {1, idx zero-extended to DATA_WIDTH}, reset `cnt` to 0, and go to COLLECT. If the FIFO is full, stay in SUMMARY.
- Output side:
  - `m_axis_tvalid = !empty`.
  - tdata/tlast come from the FIFO head.
  - A pop occurs on `tvalid && tready`.
- Push when full never occurs. `res_ready` is already low when full, and there is no same-cycle pop bypass into a full FIFO.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen, and occupancy is unchanged.
- `tx_done`: registered; high for exactly one cycle, the cycle after a handshake whose tlast=1.
- `clear`:
  - empties the FIFO.
  - sets cnt=0, state=COLLECT, and argmax to invalid.
  - any res handshake in the same cycle is discarded.
  - tx_done is suppressed.
  - clear takes priority over all other events.
- Reset (asynchronous, at any time including mid-packet):
  - FIFO empty, cnt=0, state=COLLECT.
  - outputs: res_ready=0 while reset is asserted; m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0, tx_done=0, busy=0.

## Timing
- Latency: a word accepted at cycle N on an empty FIFO appears on m_axis_tvalid/tdata at cycle N+1.
- The summary word is pushed no earlier than one cycle after the last data handshake. Input throughput is therefore NUM_OUTPUTS words per NUM_OUTPUTS+1 cycles.
- Output sustains 1 beat/cycle when tready=1 and data is present.
- AXI-Stream rule: once tvalid=1, tdata/tlast/tkeep hold stable until the handshake. tvalid never drops without a handshake, except on clear or reset.
- res_ready is combinational from registered state (state, full) only. It does not depend on res_valid.
- busy is registered, 1-cycle lag allowed.

## Test plan
- Values 0,1,...,9 sent back-to-back with tready=1:
  - 11 beats out with tdata 0..9, then 9.
  - tlast only on beat 11.
  - tx_done one pulse on the cycle after beat 11.
- Values all -5 except index 3 and index 7 = 100 (signed):
  - summary beat = 3 (tie keeps the lowest index).
  - all-equal input gives summary = 0.
- Two packets back-to-back with tready=0:
  - res_ready drops after 16 FIFO entries.
  - releasing tready outputs 22 beats in order, tlast on beats 11 and 22, two tx_done pulses.
- FIFO filled so that the final data word lands in the last free slot:
  - FSM holds in SUMMARY with res_ready=0 until one pop occurs.
  - summary is pushed the next cycle.
- clear after 4 words of a packet:
  - tvalid=0 the next cycle.
  - a following packet 9..0 produces summary = 0 with tlast on its own 11th beat.
- s_axi_aresetn pulsed low mid-output while tready=0:
  - tvalid/tlast/tdata go to 0 asynchronously.
  - after release a fresh packet transmits normally.
